// File: rtl/cpu_pkg.sv
// Shared types and constants for the microcoded control unit.
// States, opcodes, ALU selects, register addresses, control word.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_DEC,
    ST_EX,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_HALT
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_MOV  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8;
  localparam logic [4:0] OP_INCD = 5'd9;
  localparam logic [4:0] OP_STA  = 5'd10;
  localparam logic [4:0] OP_JMP  = 5'd11;
  localparam logic [4:0] OP_JZ   = 5'd12;
  localparam logic [4:0] OP_JN   = 5'd13;
  localparam logic [4:0] OP_JC   = 5'd14;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam logic [2:0] SEL_PASS = 3'd0;
  localparam logic [2:0] SEL_ADD  = 3'd1;
  localparam logic [2:0] SEL_SUB  = 3'd2;
  localparam logic [2:0] SEL_AND  = 3'd3;
  localparam logic [2:0] SEL_OR   = 3'd4;
  localparam logic [2:0] SEL_XOR  = 3'd5;
  localparam logic [2:0] SEL_SHL  = 3'd6;
  localparam logic [2:0] SEL_SHR  = 3'd7;
  // INC reuses the adder; the +1 lives on the busB path
  localparam logic [2:0] SEL_INC  = SEL_ADD;

  localparam logic [2:0] REG_PC   = 3'd0;
  localparam logic [2:0] REG_DPTR = 3'd1;
  localparam logic [2:0] REG_A    = 3'd2;
  localparam logic [2:0] REG_TEMP = 3'd3;
  localparam logic [2:0] REG_ACC  = 3'd4;

  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB_addr;
    logic [2:0] busC_addr;
    logic       ir_en;
    logic       mar_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       mdr_en;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode ROM: registered state plus latched
// opcode and current flags to the full control word.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       flag_c,
  input  logic       flag_n,
  input  logic       flag_z,
  output ctrl_t      cw
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    unique case (opcode)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = flag_z;
      OP_JN:   taken = flag_n;
      OP_JC:   taken = flag_c;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    cw = '0;
    unique case (state)
      ST_CLR: begin
        cw.ir_sclr  = 1'b1;
        cw.mar_sclr = 1'b1;
      end
      ST_F0: begin
        cw.busB_addr = REG_PC;
        cw.mar_en    = 1'b1;
      end
      ST_F1: begin
        cw.mdr_alu_n = 1'b1;
        cw.mdr_en    = 1'b1;
      end
      ST_F2: begin
        cw.ir_en      = 1'b1;
        cw.busB_addr  = REG_PC;
        cw.selop      = SEL_INC;
        cw.bank_wr_en = 1'b1;
        cw.busC_addr  = REG_PC;
      end
      ST_EX: begin
        unique case (opcode)
          OP_MOV, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            cw.busB_addr  = REG_A;
            cw.enaf       = 1'b1;
            cw.bank_wr_en = 1'b1;
            cw.busC_addr  = REG_ACC;
            unique case (opcode)
              OP_ADD:  cw.selop = SEL_ADD;
              OP_SUB:  cw.selop = SEL_SUB;
              OP_AND:  cw.selop = SEL_AND;
              OP_OR:   cw.selop = SEL_OR;
              OP_XOR:  cw.selop = SEL_XOR;
              OP_SHL:  cw.selop = SEL_SHL;
              OP_SHR:  cw.selop = SEL_SHR;
              default: cw.selop = SEL_PASS;
            endcase
            if (opcode == OP_SHL || opcode == OP_SHR)
              cw.shamt = 2'b01;
          end
          OP_INCD: begin
            cw.busB_addr  = REG_DPTR;
            cw.selop      = SEL_INC;
            cw.bank_wr_en = 1'b1;
            cw.busC_addr  = REG_DPTR;
          end
          OP_JMP, OP_JZ, OP_JN, OP_JC: begin
            if (taken) begin
              cw.busB_addr  = REG_DPTR;
              cw.bank_wr_en = 1'b1;
              cw.busC_addr  = REG_PC;
            end
          end
          default: ;
        endcase
      end
      ST_S0: begin
        cw.busB_addr = REG_DPTR;
        cw.mar_en    = 1'b1;
      end
      ST_S1: begin
        cw.busB_addr = REG_ACC;
        cw.mdr_en    = 1'b1;
      end
      ST_S2:   cw.wr_rdn = 1'b1;
      ST_HALT: cw.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch-decode-execute sequencer driving memory_system controls.
// State and opcode registers here; microcode lives in ctrl_decode.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit FETCH_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] instruction,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic       mdr_en,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [4:0] opcode_q;
  logic [4:0] op_in;
  ctrl_t      cw;
  logic       unused_p;

  assign unused_p = P;
  assign op_in = FETCH_ONLY ? OP_NOP : instruction;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= OP_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DEC)
        opcode_q <= op_in;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR:  state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2:   state_d = ST_DEC;
      ST_DEC: begin
        unique case (op_in)
          OP_HALT: state_d = ST_HALT;
          OP_STA:  state_d = ST_S0;
          default: state_d = ST_EX;
        endcase
      end
      ST_EX:   state_d = ST_F0;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  ctrl_decode u_dec (
    .state  (state_q),
    .opcode (opcode_q),
    .flag_c (C),
    .flag_n (N),
    .flag_z (Z),
    .cw     (cw)
  );

  assign ir_sclr    = cw.ir_sclr;
  assign mar_sclr   = cw.mar_sclr;
  assign enaf       = cw.enaf;
  assign selop      = cw.selop;
  assign shamt      = cw.shamt;
  assign bank_wr_en = cw.bank_wr_en;
  assign busB_addr  = cw.busB_addr;
  assign busC_addr  = cw.busC_addr;
  assign ir_en      = cw.ir_en;
  assign mar_en     = cw.mar_en;
  assign wr_rdn     = cw.wr_rdn;
  assign mdr_alu_n  = cw.mdr_alu_n;
  assign mdr_en     = cw.mdr_en;
  assign halted     = cw.halted;

endmodule

// File: tb/tb_control_unit.sv
// Randomized program bench for control_unit; expected control
// words come from a per-instruction cycle table built below.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] instruction;
  logic       C, N, P, Z;
  logic       ir_sclr, mar_sclr, enaf;
  logic [2:0] selop;
  logic [1:0] shamt;
  logic       bank_wr_en;
  logic [2:0] busB_addr, busC_addr;
  logic       ir_en, mar_en, wr_rdn;
  logic       mdr_alu_n, mdr_en, halted;

  int errs = 0;
  int checks = 0;

  control_unit #(.FETCH_ONLY(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .instruction(instruction),
    .C(C), .N(N), .P(P), .Z(Z),
    .ir_sclr(ir_sclr), .mar_sclr(mar_sclr),
    .enaf(enaf), .selop(selop), .shamt(shamt),
    .bank_wr_en(bank_wr_en),
    .busB_addr(busB_addr), .busC_addr(busC_addr),
    .ir_en(ir_en), .mar_en(mar_en), .wr_rdn(wr_rdn),
    .mdr_alu_n(mdr_alu_n), .mdr_en(mdr_en),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {ir_sclr, mar_sclr, enaf, selop, shamt,
                bank_wr_en, busB_addr, busC_addr, ir_en,
                mar_en, wr_rdn, mdr_alu_n, mdr_en, halted};

  // word layout mirrors obs; all fields named explicitly
  function automatic logic [20:0] mk(
    input logic clr, input logic ef,
    input logic [2:0] sel, input logic [1:0] sh,
    input logic bwe, input logic [2:0] bb,
    input logic [2:0] bc, input logic ir,
    input logic mar, input logic wr,
    input logic msrc, input logic men,
    input logic hlt);
    return {clr, clr, ef, sel, sh, bwe, bb, bc,
            ir, mar, wr, msrc, men, hlt};
  endfunction

  localparam logic [20:0] W0 = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // fetch: F0, F1, F2, DEC
  task automatic push_fetch(inout logic [20:0] q[$]);
    q.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,0,0));
    q.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0));
    q.push_back(mk(0,0,1,0,1,0,0,1,0,0,0,0,0));
    q.push_back(W0);
  endtask

  task automatic run_instr(input logic [4:0] op,
                           input logic fz, input logic fn,
                           input logic fc);
    logic [20:0] q[$];
    logic tk;
    instruction = op;
    Z = fz; N = fn; C = fc;
    P = 1'($urandom);
    push_fetch(q);
    if (op >= 1 && op <= 8) begin
      // ADD..SHR select = opcode-1, MOV passes through
      q.push_back(mk(0, 1, (op == 1) ? 3'd0 : 3'(op - 1),
                     (op >= 7) ? 2'd1 : 2'd0,
                     1, 2, 4, 0, 0, 0, 0, 0, 0));
    end else if (op == 9) begin
      q.push_back(mk(0,0,1,0,1,1,1,0,0,0,0,0,0));
    end else if (op == 10) begin
      q.push_back(mk(0,0,0,0,0,1,0,0,1,0,0,0,0));
    q.push_back(mk(0,0,0,0,0,4,0,0,0,0,0,1,0));
      q.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0,0));
    end else if (op >= 11 && op <= 14) begin
      tk = (op == 11) || (op == 12 && fz) ||
           (op == 13 && fn) || (op == 14 && fc);
      q.push_back(tk ? mk(0,0,0,0,1,1,0,0,0,0,0,0,0) : W0);
    end else if (op == 31) begin
      for (int i = 0; i < 20; i++)
        q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    end else begin
      q.push_back(W0);
    end
    foreach (q[i]) begin
      step();
      check($sformatf("op%0d_cyc%0d", op, i),
            32'(obs), 32'(q[i]));
      if (wr_rdn && mdr_en)
        check("wr_with_mdr_en", 32'(1), 32'(0));
      if (op == 31) start = 1'($urandom);
    end
  endtask

  task automatic start_cpu;
    start = 1'b1;
    step();
    check("clr", 32'(obs),
          32'(mk(1,0,0,0,0,0,0,0,0,0,0,0,0)));
    start = 1'b0;
  endtask

  initial begin
    logic [4:0] op;
    rst = 1'b0;
    start = 1'b0;
    instruction = '0;
    {C, N, P, Z} = '0;
    step();
    step();
    check("reset", 32'(obs), 32'(W0));
    rst = 1'b1;
    step();
    check("idle", 32'(obs), 32'(W0));

    start_cpu();
    step();
    check("f0", 32'(obs),
          32'(mk(0,0,0,0,0,0,0,0,1,0,0,0,0)));
    step();
    check("f1", 32'(obs),
          32'(mk(0,0,0,0,0,0,0,0,0,0,1,1,0)));
    rst = 1'b0;
    #1;
    check("rst_async", 32'(obs), 32'(W0));
    step();
    check("rst_hold", 32'(obs), 32'(W0));
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_after_rst", 32'(obs), 32'(W0));
    end

    start_cpu();
    run_instr(5'd2, 0, 0, 0);
    run_instr(5'd12, 1, 0, 0);
    run_instr(5'd12, 0, 1, 1);
    run_instr(5'd10, 0, 0, 0);
    run_instr(5'd20, 1, 1, 1);
    run_instr(5'd7, 0, 0, 0);
    run_instr(5'd11, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 30));
      run_instr(op, 1'($urandom), 1'($urandom),
                1'($urandom));
    end
    run_instr(5'd31, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
